// File: rtl/tick_sched.sv
// -----------------------------------------------------------------------------
// tick_sched
//   Shares one programmable tick divider among NREQ requesters. Requests are
//   arbitrated round-robin. The winner's divisor is loaded into the shared
//   divider, which is then restarted. Divider ticks are counted until the
//   winner's tick count is reached, and then a one-cycle done pulse is given.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   req      in   [NREQ]      request level per requester, held until done/abort
//   req_div  in   [NREQ*DW]   divisor per requester (slice i = [i*DW +: DW])
//   req_cnt  in   [NREQ*DW]   tick count per requester (same slicing)
//   gnt      out  [NREQ]      one-hot grant level
//   done     out  [NREQ]      one-cycle completion pulse
//   busy     out              high whenever the scheduler is not idle
//   div_out  out  [DW]        divisor driven to the shared divider
//   div_rst  out              reset driven to the shared divider
//   tick_in  in               tick pulse from the shared divider
// -----------------------------------------------------------------------------
module tick_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_div,
    input  logic [NREQ*DW-1:0] req_cnt,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [DW-1:0]      div_out,
    output logic               div_rst,
    input  logic               tick_in
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_g;
    logic [DW-1:0]   r_rem;
    logic            r_first;
    logic [DW-1:0]   r_div;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_busy;
    logic            r_div_rst;

    logic [IW-1:0]   w_next_last;
    logic [IW-1:0]   w_next_g;
    logic [DW-1:0]   w_next_rem;
    logic            w_next_first;
    logic [DW-1:0]   w_next_div;
    logic [NREQ-1:0] w_next_gnt;
    logic [NREQ-1:0] w_next_done;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [IW:0]     w_sum;
    logic [DW-1:0]   w_sel_div;
    logic [DW-1:0]   w_sel_cnt;

    // Fields of the current grantee; only consumed in LOAD.
    assign w_sel_div = req_div[int'(r_g)*DW +: DW];
    assign w_sel_cnt = req_cnt[int'(r_g)*DW +: DW];

    // Round-robin pick: first set req bit scanning from last+1 with wrap.
    // The sum is one bit wider so the wrap works for any NREQ, not just 2^n.
    // NOTE: every signal driven in always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_any = 1'b0;
        w_win = r_last;
        w_sum = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            if (!w_any && req[w_sum[IW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_sum[IW-1:0];
            end
        end
    end

    // Next-state and next-output logic. Outputs are registered from the next
    // state, so they line up with the state cycle and are glitch-free.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_next_g     = r_g;
        w_next_rem   = r_rem;
        w_next_first = r_first;
        w_next_div   = r_div;

        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next_g     = w_win;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_div   = w_sel_div;
                w_next_rem   = w_sel_cnt;
                w_next_first = 1'b1;
                w_next_state = (w_sel_cnt == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // The tick in the first RUN cycle is the divider's post-reset
                // pulse, not a full period, so it is not counted.
                w_next_first = 1'b0;
                if (!req[r_g]) begin
                    // Abort wins over a tick arriving in the same cycle.
                    w_next_last  = r_g;
                    w_next_state = S_IDLE;
                end else if (tick_in && !r_first) begin
                    w_next_rem = r_rem - 1'b1;
                    if (r_rem == DW'(1)) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next_last  = r_g;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        w_next_gnt  = '0;
        w_next_done = '0;
        if (w_next_state == S_LOAD || w_next_state == S_RUN) begin
            w_next_gnt[w_next_g] = 1'b1;
        end
        if (w_next_state == S_DONE) begin
            w_next_done[w_next_g] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= LAST_RST;
            r_g       <= '0;
            r_rem     <= '0;
            r_first   <= 1'b0;
            r_div     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_div_rst <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_last    <= w_next_last;
            r_g       <= w_next_g;
            r_rem     <= w_next_rem;
            r_first   <= w_next_first;
            r_div     <= w_next_div;
            r_gnt     <= w_next_gnt;
            r_done    <= w_next_done;
            r_busy    <= (w_next_state != S_IDLE);
            r_div_rst <= (w_next_state == S_LOAD);
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign busy    = r_busy;
    assign div_out = r_div;
    assign div_rst = r_div_rst;

endmodule
